// File: rtl/rdid_responder.sv
`timescale 1ns/1ps
// SPI-flash-side RDID (0x9F) responder: oversamples the SPI pins in the clk domain and returns the JEDEC ID.
// Optional RDSR (0x05) support is compiled in when RDID_RSP_RDSR_EN is defined.
module rdid_responder #(
  parameter logic [7:0] MANUF_ID    = 8'h20,
  parameter logic [7:0] MEM_TYPE    = 8'h20,
  parameter logic [7:0] MEM_CAP     = 8'h15,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spisck,
  input  logic       spimosi,
  input  logic       prom_cs_n,
  output logic       spimiso,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       busy
);

  // state     | meaning
  // WAIT_CS   | after reset; wait for a real cs_n=1 so a frame in progress is never joined
  // IDLE      | deselected, waiting for cs fall
  // CMD       | shifting in the command byte on sck rise
  // ID_OUT    | shifting JEDEC ID bytes out on sck fall, wrapping every 3 bytes
  // STAT_OUT  | shifting the status byte (00) out on sck fall
  // IGNORE    | unknown command; spimiso held 0 until cs rise
  typedef enum logic [2:0] {
    ST_WAIT_CS,
    ST_IDLE,
    ST_CMD,
    ST_ID_OUT,
`ifdef RDID_RSP_RDSR_EN
    ST_STAT_OUT,
`endif
    ST_IGNORE
  } state_t;

  localparam int PW = $clog2(SYNC_STAGES + 1) + 1;

`ifdef RDID_RSP_RDSR_EN
  localparam logic [7:0] STATUS_BYTE = 8'h00;
`endif

  logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, cs_sync;
  logic                   sck_d, cs_d;
  logic [PW-1:0]          prime_cnt;

  state_t     state, state_nxt;
  logic [7:0] shift_reg, shift_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [1:0] byte_idx, byte_idx_nxt;
  logic       skip_rise, skip_nxt;
  logic       miso_q, miso_nxt;
  logic       cmd_valid_q, cmd_valid_nxt;
  logic [7:0] cmd_byte_q, cmd_byte_nxt;

  logic       sck_s, mosi_s, cs_s;
  logic       sck_rise, sck_fall, cs_fall, cs_rise;
  logic [7:0] shift_in;
  logic [7:0] id_byte;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign cs_rise  = cs_s & ~cs_d;
  assign shift_in = {shift_reg[6:0], mosi_s};

  always_comb begin
    case (byte_idx)
      2'd0:    id_byte = MANUF_ID;
      2'd1:    id_byte = MEM_TYPE;
      default: id_byte = MEM_CAP;
    endcase
  end

  // Sync chains reset to idle levels; prime_cnt marks when the chain holds real pin samples.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
      prime_cnt <= PW'(SYNC_STAGES);
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spisck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spimosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], prom_cs_n};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
      if (prime_cnt != '0) prime_cnt <= prime_cnt - PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_WAIT_CS;
      shift_reg   <= 8'h00;
      bit_cnt     <= 3'd0;
      byte_idx    <= 2'd0;
      skip_rise   <= 1'b0;
      miso_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_byte_q  <= 8'h00;
    end else begin
      state       <= state_nxt;
      shift_reg   <= shift_nxt;
      bit_cnt     <= bit_cnt_nxt;
      byte_idx    <= byte_idx_nxt;
      skip_rise   <= skip_nxt;
      miso_q      <= miso_nxt;
      cmd_valid_q <= cmd_valid_nxt;
      cmd_byte_q  <= cmd_byte_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    shift_nxt     = shift_reg;
    bit_cnt_nxt   = bit_cnt;
    byte_idx_nxt  = byte_idx;
    skip_nxt      = skip_rise;
    miso_nxt      = miso_q;
    cmd_valid_nxt = 1'b0;
    cmd_byte_nxt  = cmd_byte_q;

    case (state)
      ST_WAIT_CS: begin
        miso_nxt = 1'b0;
        if (prime_cnt == '0 && cs_s) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        miso_nxt = 1'b0;
        if (cs_fall) begin
          state_nxt   = ST_CMD;
          bit_cnt_nxt = 3'd0;
          shift_nxt   = 8'h00;
          // cs fell with sck already high: the next rise does not carry a bit
          skip_nxt    = sck_s;
        end
      end
      ST_CMD: begin
        if (sck_rise) begin
          if (skip_rise) begin
            skip_nxt = 1'b0;
          end else begin
            shift_nxt   = shift_in;
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              cmd_byte_nxt  = shift_in;
              cmd_valid_nxt = 1'b1;
              byte_idx_nxt  = 2'd0;
              bit_cnt_nxt   = 3'd0;
              if (shift_in == 8'h9F)
                state_nxt = ST_ID_OUT;
`ifdef RDID_RSP_RDSR_EN
              else if (shift_in == 8'h05)
                state_nxt = ST_STAT_OUT;
`endif
              else
                state_nxt = ST_IGNORE;
            end
          end
        end
      end
      ST_ID_OUT: begin
        if (sck_fall) begin
          miso_nxt    = id_byte[3'd7 - bit_cnt];
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7)
            byte_idx_nxt = (byte_idx == 2'd2) ? 2'd0 : byte_idx + 2'd1;
        end
      end
`ifdef RDID_RSP_RDSR_EN
      ST_STAT_OUT: begin
        if (sck_fall) begin
          miso_nxt    = STATUS_BYTE[3'd7 - bit_cnt];
          bit_cnt_nxt = bit_cnt + 3'd1;
        end
      end
`endif
      ST_IGNORE: miso_nxt = 1'b0;
      default:   state_nxt = ST_WAIT_CS;
    endcase

    // cs rise ends any frame and wins over an sck edge seen in the same clk
    if (state != ST_WAIT_CS && cs_rise) begin
      state_nxt     = ST_IDLE;
      shift_nxt     = 8'h00;
      bit_cnt_nxt   = 3'd0;
      byte_idx_nxt  = 2'd0;
      skip_nxt      = 1'b0;
      miso_nxt      = 1'b0;
      cmd_valid_nxt = 1'b0;
      cmd_byte_nxt  = cmd_byte_q;
    end
  end

  assign spimiso   = miso_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_byte  = cmd_byte_q;
  assign busy      = ~cs_s & (state != ST_IDLE);

endmodule

// File: tb/tb_rdid_responder.sv
`timescale 1ns/1ps
// Bench for rdid_responder: a bit-banged SPI mode-0 master with random commands and timing,
// checked against the JEDEC read-back sequence the flash is supposed to produce.
module tb_rdid_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       spisck;
  logic       spimosi;
  logic       prom_cs_n;
  logic       spimiso;
  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       busy;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         vld_total = 0;
  logic [7:0] vld_byte = 8'h00;
  logic [7:0] last_cmd;
  int         half;

  localparam logic [7:0] ID0 = 8'h20, ID1 = 8'h20, ID2 = 8'h15;

  rdid_responder dut (
    .clk       (clk),
    .rst       (rst),
    .spisck    (spisck),
    .spimosi   (spimosi),
    .prom_cs_n (prom_cs_n),
    .spimiso   (spimiso),
    .cmd_valid (cmd_valid),
    .cmd_byte  (cmd_byte),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (cmd_valid === 1'b1) begin
      vld_total <= vld_total + 1;
      vld_byte  <= cmd_byte;
    end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected k-th response byte: ID sequence wraps every 3 bytes; anything else reads as zero
  function automatic logic [7:0] ref_byte(input logic [7:0] cmd, input int k);
    logic [7:0] ids [3];
    ids[0] = ID0; ids[1] = ID1; ids[2] = ID2;
    return (cmd == 8'h9F) ? ids[k % 3] : 8'h00;
  endfunction

  task automatic frame(input logic [7:0] cmd, input int cmd_bits, input int resp_bytes,
                       input int rst_bit, output logic [63:0] resp, output int pulses);
    int v0;
    v0   = vld_total;
    resp = '0;
    @(negedge clk);
    prom_cs_n = 1'b0;
    spimosi   = 1'b0;
    wait_clk(half);
    for (int i = 0; i < cmd_bits + 8 * resp_bytes; i++) begin
      spimosi = (i < 8) ? cmd[7 - i] : 1'($urandom_range(0, 1));
      if (i == rst_bit) begin
        rst = 1'b0;
        wait_clk(2);
        rst = 1'b1;
      end
      wait_clk(half);
      if (i >= cmd_bits) resp = {resp[62:0], spimiso};
      spisck = 1'b1;
      wait_clk(half);
      spisck = 1'b0;
    end
    wait_clk(half);
    if (rst_bit < 0) chk("busy_in_frame", 64'(busy), 64'd1);
    prom_cs_n = 1'b1;
    wait_clk(half + 4);
    chk("busy_after_cs", 64'(busy), 64'd0);
    chk("miso_idle", 64'(spimiso), 64'd0);
    pulses = vld_total - v0;
  endtask

  task automatic run_frame(input logic [7:0] cmd, input int cmd_bits, input int nbytes);
    logic [63:0] resp;
    int          pulses;
    frame(cmd, cmd_bits, nbytes, -1, resp, pulses);
    for (int k = 0; k < nbytes; k++)
      chk($sformatf("resp_%02h_b%0d", cmd, k), 64'(8'(resp >> (8 * (nbytes - 1 - k)))),
          64'(ref_byte(cmd, k)));
    if (cmd_bits >= 8) begin
      last_cmd = cmd;
      chk("vld_pulses", 64'(pulses), 64'd1);
      chk("vld_byte", 64'(vld_byte), 64'(cmd));
    end else begin
      chk("vld_pulses_partial", 64'(pulses), 64'd0);
    end
    chk("cmd_byte", 64'(cmd_byte), 64'(last_cmd));
  endtask

  initial begin
    logic [63:0] resp;
    int          pulses;
    logic [7:0]  c;
    rst       = 1'b0;
    spisck    = 1'b0;
    spimosi   = 1'b0;
    prom_cs_n = 1'b1;
    half      = 6;
    last_cmd  = 8'h00;
    wait_clk(2);
    rst = 1'b1;
    wait_clk(6);
    chk("rst_miso", 64'(spimiso), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(cmd_valid), 64'd0);
    chk("rst_cmd_byte", 64'(cmd_byte), 64'd0);

    run_frame(8'h9F, 8, 3);
    run_frame(8'h9F, 8, 6);
    run_frame(8'hAB, 8, 2);
    run_frame(8'h05, 8, 2);
    run_frame(8'h9F, 4, 0);
    run_frame(8'h9F, 8, 3);

    // reset during the second ID byte with cs held low, then a clean frame
    frame(8'h9F, 8, 3, 19, resp, pulses);
    chk("rst_mid_b0", 64'(resp[23:16]), 64'(ID0));
    chk("rst_mid_b1_tail", 64'(resp[12:8]), 64'd0);
    chk("rst_mid_b2", 64'(resp[7:0]), 64'd0);
    chk("rst_mid_pulses", 64'(pulses), 64'd1);
    chk("rst_mid_cmd_byte", 64'(cmd_byte), 64'd0);
    last_cmd = 8'h00;
    run_frame(8'h9F, 8, 3);

    for (int n = 0; n < 10; n++) begin
      half = $urandom_range(5, 9);
      case ($urandom_range(0, 3))
        0, 1:    c = 8'h9F;
        2:       c = 8'h05;
        default: c = 8'($urandom);
      endcase
      if ($urandom_range(0, 4) == 0)
        run_frame(c, $urandom_range(1, 7), 0);
      else
        run_frame(c, 8, $urandom_range(1, 6));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
